// File: rtl/tpic_pkg.sv
// Shared types and default timing for the TPIC relay-chain frame controller.
package tpic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH,
    ST_BYPASS
  } tpic_state_e;

  localparam int TPIC_WIDTH      = 300;
  localparam int TPIC_SCLK_HALF  = 2;
  localparam int TPIC_RCK_CYCLES = 2;
  localparam int TPIC_REFRESH    = 50000;

endpackage

// File: rtl/tpic_frame_ctrl_if.sv
// TPIC daisy-chain pin bundle: the controller drives the chain, the chain returns SOUT as sin.
interface tpic_frame_ctrl_if;
  logic tpic_sclk;
  logic tpic_sout;
  logic tpic_rck;
  logic tpic_en_n;
  logic tpic_sin;

  modport master (
    output tpic_sclk,
    output tpic_sout,
    output tpic_rck,
    output tpic_en_n,
    input  tpic_sin
  );

  modport slave (
    input  tpic_sclk,
    input  tpic_sout,
    input  tpic_rck,
    input  tpic_en_n,
    output tpic_sin
  );
endinterface

// File: rtl/tpic_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset.
module tpic_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];
endmodule

// File: rtl/tpic_frame_ctrl.sv
// Frame sequencer for the TPIC relay chain: snapshot, MSB-first shift with readback, RCK latch,
// and frame-boundary handover of the pins to the diagnostic bypass.
module tpic_frame_ctrl
  import tpic_pkg::*;
#(
  parameter int WIDTH      = TPIC_WIDTH,
  parameter int SCLK_HALF  = TPIC_SCLK_HALF,
  parameter int RCK_CYCLES = TPIC_RCK_CYCLES,
  parameter int REFRESH    = TPIC_REFRESH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   mem_data,
  input  logic               mem_wr,
  input  logic               byps_req,
  input  logic               err_clr,
  output logic               byps_gnt,
  output logic               busy,
  output logic               frame_done,
  output logic               chain_err,
  tpic_frame_ctrl_if.master  tpic
);

  localparam int PW = (SCLK_HALF > RCK_CYCLES) ? SCLK_HALF : RCK_CYCLES;
  localparam int CW = (PW > 1) ? $clog2(PW) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(SCLK_HALF - 1);
  localparam logic [CW-1:0] RCK_LAST  = CW'(RCK_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [RW-1:0] REF_LAST  = RW'((REFRESH > 0) ? REFRESH - 1 : 0);

  tpic_state_e      state_q;
  logic [CW-1:0]    cnt_q;
  logic [BW-1:0]    bit_q;
  logic [RW-1:0]    ref_q;
  logic [WIDTH-1:0] tx_q;
  logic [WIDTH-1:0] snap_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rx_q;
  logic             pending_q;
  logic             chk_valid_q;
  logic             byps_gnt_q;
  logic             sclk_q;
  logic             sout_q;
  logic             rck_q;
  logic             en_n_q;
  logic             busy_q;
  logic             frame_done_q;
  logic             chain_err_q;
  logic             byps_s;
  logic             mismatch;

  tpic_sync2 u_byps_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   (byps_req),
    .q_o   (byps_s)
  );

  assign mismatch = chk_valid_q && (rx_q != prev_q);

  // Pin outputs are registered and updated on the transition into the state that owns them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      ref_q        <= '0;
      tx_q         <= '0;
      snap_q       <= '0;
      prev_q       <= '0;
      rx_q         <= '0;
      pending_q    <= 1'b1;
      chk_valid_q  <= 1'b0;
      byps_gnt_q   <= 1'b0;
      sclk_q       <= 1'b0;
      sout_q       <= 1'b0;
      rck_q        <= 1'b0;
      en_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      chain_err_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (err_clr) begin
        chain_err_q <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (byps_s) begin
            state_q    <= ST_BYPASS;
            byps_gnt_q <= 1'b1;
          end else if (pending_q) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end else if (REFRESH != 0) begin
            if (ref_q == REF_LAST) begin
              pending_q <= 1'b1;
              ref_q     <= '0;
            end else begin
              ref_q <= ref_q + 1'b1;
            end
          end
        end

        ST_LOAD: begin
          tx_q      <= mem_data;
          snap_q    <= mem_data;
          sout_q    <= mem_data[WIDTH-1];
          pending_q <= 1'b0;
          bit_q     <= '0;
          cnt_q     <= '0;
          state_q   <= ST_SHIFT_LO;
        end

        ST_SHIFT_LO: begin
          if (cnt_q == HALF_LAST) begin
            rx_q    <= {rx_q[WIDTH-2:0], tpic.tpic_sin};
            sclk_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_SHIFT_HI;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_SHIFT_HI: begin
          if (cnt_q == HALF_LAST) begin
            tx_q   <= {tx_q[WIDTH-2:0], 1'b0};
            bit_q  <= bit_q + 1'b1;
            cnt_q  <= '0;
            sclk_q <= 1'b0;
            if (bit_q == BIT_LAST) begin
              state_q <= ST_LATCH;
              sout_q  <= 1'b0;
              rck_q   <= 1'b1;
            end else begin
              state_q <= ST_SHIFT_LO;
              sout_q  <= tx_q[WIDTH-2];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_LATCH: begin
          // Placed after the err_clr default so a same-cycle mismatch wins.
          if ((cnt_q == '0) && mismatch) begin
            chain_err_q <= 1'b1;
          end
          if (cnt_q == RCK_LAST) begin
            prev_q       <= snap_q;
            chk_valid_q  <= 1'b1;
            en_n_q       <= 1'b0;
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            rck_q        <= 1'b0;
            cnt_q        <= '0;
            state_q      <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_BYPASS: begin
          if (!byps_s) begin
            state_q     <= ST_IDLE;
            byps_gnt_q  <= 1'b0;
            pending_q   <= 1'b1;
            chk_valid_q <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      if (mem_wr) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign byps_gnt       = byps_gnt_q;
  assign busy           = busy_q;
  assign frame_done     = frame_done_q;
  assign chain_err      = chain_err_q;
  assign tpic.tpic_sclk = sclk_q;
  assign tpic.tpic_sout = sout_q;
  assign tpic.tpic_rck  = rck_q;
  assign tpic.tpic_en_n = en_n_q;

endmodule

// File: tb/tb_tpic_frame_ctrl.sv
// Bench for tpic_frame_ctrl: loopback chain model, frame vector table, hand sequences, random writes.
module tb_tpic_frame_ctrl;
  localparam int W    = 16;
  localparam int SH   = 2;
  localparam int RC   = 2;
  localparam int FLEN = 1 + 2 * SH * W + RC;
  // 100 counted idle cycles, plus the idle cycle that acts on the raised request.
  localparam int RGAP = 101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, rst_r_n;
  logic [W-1:0] mem_data, mem_data_r;
  logic         mem_wr, byps_req, err_clr;
  logic         byps_gnt, busy, frame_done, chain_err;
  logic         gnt_r, busy_r, fd_r, err_r;
  logic         zero_r;
  logic [1:0]   fault;

  tpic_frame_ctrl_if bus_a ();
  tpic_frame_ctrl_if bus_r ();

  tpic_frame_ctrl #(.WIDTH(W), .SCLK_HALF(SH), .RCK_CYCLES(RC), .REFRESH(0)) dut (
    .clk(clk), .reset_n(rst_n), .mem_data(mem_data), .mem_wr(mem_wr),
    .byps_req(byps_req), .err_clr(err_clr), .byps_gnt(byps_gnt), .busy(busy),
    .frame_done(frame_done), .chain_err(chain_err), .tpic(bus_a)
  );

  tpic_frame_ctrl #(.WIDTH(W), .SCLK_HALF(SH), .RCK_CYCLES(RC), .REFRESH(100)) dut_r (
    .clk(clk), .reset_n(rst_r_n), .mem_data(mem_data_r), .mem_wr(zero_r),
    .byps_req(zero_r), .err_clr(zero_r), .byps_gnt(gnt_r), .busy(busy_r),
    .frame_done(fd_r), .chain_err(err_r), .tpic(bus_r)
  );

  // Loopback chain: W-stage shift register clocked by sclk, last stage feeds back as sin.
  logic [W-1:0] chain;
  logic [W-1:0] bits;
  assign bus_a.tpic_sin = (fault == 2'd1) ? 1'b0 : (fault == 2'd2) ? 1'b1 : chain[W-1];
  assign bus_r.tpic_sin = 1'b0;
  assign zero_r = 1'b0;

  always @(posedge bus_a.tpic_sclk) begin
    chain <= {chain[W-2:0], bus_a.tpic_sout};
    bits  <= {bits[W-2:0], bus_a.tpic_sout};
  end

  // Frame monitor for dut: per-frame measurements plus a request model (a frame may start only
  // after reset, a write, or bypass release since the previous LOAD).
  int           len_c, rck_c, sclk_c, hi_run;
  int           last_len, last_rck, last_sclk, frames;
  int           hi_bad, len_bad, bits_bad, req_bad, fd_stray;
  logic [W-1:0] snap_exp, last_bits;
  logic         busy_p, sclk_p, gnt_p, req_m;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_p = 1'b0; sclk_p = 1'b0; gnt_p = 1'b0; req_m = 1'b1;
      len_c = 0; rck_c = 0; sclk_c = 0; hi_run = 0;
      frames = 0; hi_bad = 0; len_bad = 0; bits_bad = 0; req_bad = 0; fd_stray = 0;
      last_len = 0; last_rck = 0; last_sclk = 0;
    end else begin
      if (busy && !busy_p) begin
        if (!req_m) req_bad++;
        req_m = 1'b0;
        snap_exp = mem_data;
        len_c = 0; rck_c = 0; sclk_c = 0;
      end
      if (mem_wr) req_m = 1'b1;
      if (gnt_p && !byps_gnt) req_m = 1'b1;
      if (busy) begin
        len_c++;
        if (bus_a.tpic_rck) rck_c++;
        if (bus_a.tpic_sclk && !sclk_p) sclk_c++;
      end
      if (bus_a.tpic_sclk) hi_run++;
      else begin
        if (sclk_p && hi_run != SH) hi_bad++;
        hi_run = 0;
      end
      if (!busy && busy_p) begin
        last_len = len_c; last_rck = rck_c; last_sclk = sclk_c; last_bits = bits;
        if (len_c != FLEN) len_bad++;
        if (bits != snap_exp) bits_bad++;
        if (!frame_done) fd_stray++;
        frames++;
      end else if (frame_done) begin
        fd_stray++;
      end
      busy_p = busy; sclk_p = bus_a.tpic_sclk; gnt_p = byps_gnt;
    end
  end

  // Idle-gap monitor for the refresh instance.
  int   gaps [4];
  int   gap_n, low_c;
  logic busy_rp, seen_fall;

  always @(negedge clk) begin
    if (!rst_r_n) begin
      busy_rp = 1'b0; seen_fall = 1'b0; low_c = 0;
    end else begin
      if (!busy_r && busy_rp) begin
        seen_fall = 1'b1; low_c = 1;
      end else if (!busy_r) begin
        low_c++;
      end
      if (busy_r && !busy_rp && seen_fall && gap_n < 4) begin
        gaps[gap_n] = low_c;
        gap_n++;
      end
      busy_rp = busy_r;
    end
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic write_mem(input logic [W-1:0] d);
    @(posedge clk); #2;
    mem_data = d; mem_wr = 1'b1;
    @(posedge clk); #2;
    mem_wr = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #2; err_clr = 1'b1;
    @(posedge clk); #2; err_clr = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    int f0;
    f0 = frames;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (frames >= f0 + n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (busy) begin ok = 1'b1; break; end
    end
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   flt;
    bit           clr;
    bit           exp_err;
  } vec_t;

  vec_t vec [7];

  initial begin
    automatic bit ok;
    automatic int n, bad, f0;

    // prev/chain before each row is the previous row's data (first row: the reset frame A5C3).
    vec[0] = '{16'h1234, 2'd0, 1'b0, 1'b0};
    vec[1] = '{16'h00FF, 2'd0, 1'b0, 1'b0};
    vec[2] = '{16'hFFFF, 2'd1, 1'b0, 1'b1};
    vec[3] = '{16'h0F0F, 2'd0, 1'b1, 1'b0};
    vec[4] = '{16'h8001, 2'd2, 1'b0, 1'b1};
    vec[5] = '{16'h7E7E, 2'd0, 1'b0, 1'b1};
    vec[6] = '{16'h3C3C, 2'd0, 1'b1, 1'b0};

    rst_n = 1'b0; rst_r_n = 1'b0;
    mem_data = 16'hA5C3; mem_data_r = 16'hBEEF;
    mem_wr = 1'b0; byps_req = 1'b0; err_clr = 1'b0; fault = 2'd0;
    gap_n = 0;
    #23;
    chk("reset_outputs", {byps_gnt, bus_a.tpic_sclk, bus_a.tpic_sout, bus_a.tpic_rck,
                          bus_a.tpic_en_n, busy, frame_done, chain_err}, 8'b0000_1000);
    @(posedge clk); #2;
    rst_n = 1'b1; rst_r_n = 1'b1;

    // Reset frame.
    wait_busy(ok);
    chk("first_frame_start", ok, 1);
    chk("en_n_before_first", bus_a.tpic_en_n, 1);
    wait_frames(1, 200, ok);
    chk("first_frame_timeout", ok, 1);
    chk("first_bits", last_bits, 16'hA5C3);
    chk("first_len", last_len, FLEN);
    chk("first_rck_cycles", last_rck, RC);
    chk("first_sclk_pulses", last_sclk, W);
    chk("first_sclk_high_runs", hi_bad, 0);
    chk("first_en_n", bus_a.tpic_en_n, 0);
    chk("first_chain_err", chain_err, 0);

    // Vector table.
    for (int i = 0; i < 7; i++) begin
      if (vec[i].clr) begin
        pulse_clr();
        @(negedge clk); #1;
        chk("err_clr_clears", chain_err, 0);
      end
      @(posedge clk); #2;
      fault = vec[i].flt;
      write_mem(vec[i].data);
      wait_frames(1, 300, ok);
      chk("vec_timeout", ok, 1);
      chk("vec_bits", last_bits, vec[i].data);
      chk("vec_chain_err", chain_err, vec[i].exp_err);
      chk("vec_len", last_len, FLEN);
    end

    // Mismatch and err_clr in the same cycle: the set wins.
    @(posedge clk); #2;
    fault = 2'd1;
    write_mem(16'h5555);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (bus_a.tpic_rck) begin ok = 1'b1; break; end
    end
    err_clr = 1'b1;
    @(posedge clk); #2;
    err_clr = 1'b0;
    chk("rck_seen", ok, 1);
    wait_frames(1, 100, ok);
    chk("setwins_timeout", ok, 1);
    chk("setwins_chain_err", chain_err, 1);
    pulse_clr();
    @(posedge clk); #2;
    fault = 2'd0;

    // Three writes during a frame coalesce into one follow-up frame.
    write_mem(16'h1111);
    wait_busy(ok);
    chk("coal_start", ok, 1);
    f0 = frames;
    repeat (6) @(posedge clk);
    write_mem(16'h2222);
    repeat (6) @(posedge clk);
    write_mem(16'h3333);
    repeat (6) @(posedge clk);
    write_mem(16'h4444);
    wait_frames(2, 400, ok);
    chk("coal_timeout", ok, 1);
    chk("coal_bits", last_bits, 16'h4444);
    repeat (200) @(negedge clk);
    #1;
    chk("coal_frame_count", frames, f0 + 2);
    chk("coal_chain_err", chain_err, 0);

    // Bypass requested at bit 5: frame completes, then pins are handed over.
    write_mem(16'h6666);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (busy && sclk_c >= 5) break;
    end
    byps_req = 1'b1;
    wait_frames(1, 200, ok);
    chk("byps_frame_timeout", ok, 1);
    chk("byps_frame_len", last_len, FLEN);
    chk("byps_frame_bits", last_bits, 16'h6666);
    n = 0;
    while (!byps_gnt && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    chk("byps_gnt_latency_ok", (n <= 3), 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (bus_a.tpic_sclk || bus_a.tpic_sout || bus_a.tpic_rck || !byps_gnt ||
          bus_a.tpic_en_n || busy) bad++;
    end
    write_mem(16'h7777);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (bus_a.tpic_sclk || bus_a.tpic_sout || bus_a.tpic_rck || !byps_gnt ||
          bus_a.tpic_en_n || busy) bad++;
    end
    chk("byps_pins_idle", bad, 0);
    fault = 2'd1;
    byps_req = 1'b0;
    n = 0;
    while (byps_gnt && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    chk("byps_release", byps_gnt, 0);
    wait_frames(1, 200, ok);
    chk("post_byps_frame", ok, 1);
    chk("post_byps_bits", last_bits, 16'h7777);
    chk("post_byps_no_check", chain_err, 0);
    @(posedge clk); #2;
    fault = 2'd0;
    write_mem(16'h8888);
    wait_frames(1, 200, ok);
    chk("post_byps2_timeout", ok, 1);
    chk("post_byps2_chain_err", chain_err, 0);

    // Random writes and data; monitor checks every frame against its LOAD snapshot.
    f0 = frames;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #2;
      mem_data = W'($urandom);
      mem_wr = ($urandom_range(0, 24) == 0);
    end
    @(posedge clk); #2;
    mem_wr = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (!busy && !req_m) begin ok = 1'b1; break; end
    end
    repeat (20) @(negedge clk);
    #1;
    chk("rand_settle", ok, 1);
    chk("rand_frames_seen", (frames > f0 + 5), 1);
    chk("rand_no_spurious_frame", busy, 0);
    chk("all_bits_bad", bits_bad, 0);
    chk("all_len_bad", len_bad, 0);
    chk("all_req_bad", req_bad, 0);
    chk("all_fd_stray", fd_stray, 0);
    chk("all_sclk_high_runs", hi_bad, 0);
    chk("rand_chain_err", chain_err, 0);

    // Periodic refresh instance.
    for (int i = 0; i < 1000 && gap_n < 3; i++) @(negedge clk);
    #1;
    chk("refresh_gaps_seen", (gap_n >= 3), 1);
    chk("refresh_gap0", gaps[0], RGAP);
    chk("refresh_gap1", gaps[1], RGAP);
    chk("refresh_gap2", gaps[2], RGAP);

    // Asynchronous reset during SHIFT_HI.
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (bus_r.tpic_sclk) begin ok = 1'b1; break; end
    end
    chk("refresh_sclk_seen", ok, 1);
    #1;
    rst_r_n = 1'b0;
    #1;
    chk("midframe_reset_outputs", {gnt_r, bus_r.tpic_sclk, bus_r.tpic_sout, bus_r.tpic_rck,
                                   bus_r.tpic_en_n, busy_r, fd_r, err_r}, 8'b0000_1000);
    repeat (3) @(posedge clk);
    #2;
    rst_r_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (busy_r) begin ok = 1'b1; break; end
    end
    chk("fresh_frame_after_reset", ok, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: run did not end, %0d of %0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule
